// File: rtl/fano_pkg.sv
// Shared types and helpers for the Fano decoder front end.
package fano_pkg;

    typedef logic [2:0] phase_t;

    localparam int NUM_PHASES_BASE = 4;

    // Two's-complement negation of a w-bit value held sign-extended in 32 bits;
    // the most negative w-bit value maps to the most positive instead of wrapping.
    function automatic logic signed [31:0] sat_neg(input logic signed [31:0] x,
                                                   input int w);
        logic signed [31:0] lo;
        lo = -(32'sd1 <<< (w - 1));
        return (x == lo) ? ~lo : -x;
    endfunction

endpackage

// File: rtl/llr_phase_former_if.sv
// Symbol-in / LLR-pair-out stream bundle for llr_phase_former.
// master: upstream demodulator + downstream depuncturer side; slave: the former itself.
interface llr_phase_former_if #(
    parameter int IN_WIDTH  = 8,
    parameter int LLR_WIDTH = 4
);

    logic                        s_valid;
    logic                        s_ready;
    logic signed [IN_WIDTH-1:0]  s_i;
    logic signed [IN_WIDTH-1:0]  s_q;
    logic                        m_valid;
    logic                        m_ready;
    logic signed [LLR_WIDTH-1:0] m_llr0;
    logic signed [LLR_WIDTH-1:0] m_llr1;

    modport master (
        output s_valid, s_i, s_q, m_ready,
        input  s_ready, m_valid, m_llr0, m_llr1
    );

    modport slave (
        input  s_valid, s_i, s_q, m_ready,
        output s_ready, m_valid, m_llr0, m_llr1
    );

endinterface

// File: rtl/llr_quantizer.sv
// Combinational soft-value quantizer: round-half-up right shift followed by
// symmetric saturation to the LLR range.
module llr_quantizer #(
    parameter int IN_WIDTH  = 8,
    parameter int LLR_WIDTH = 4,
    parameter int SHIFT_W   = 3
) (
    input  logic signed [IN_WIDTH-1:0]  din,
    input  logic        [SHIFT_W-1:0]   shift,
    output logic signed [LLR_WIDTH-1:0] dout
);

    localparam int LMAX = (1 << (LLR_WIDTH - 1)) - 1;

    // One guard bit above the input keeps the rounding bias from wrapping.
    function automatic logic signed [IN_WIDTH:0] round_shift(
        input logic signed [IN_WIDTH-1:0] x,
        input logic        [SHIFT_W-1:0]  s
    );
        logic signed [IN_WIDTH:0] ext;
        logic signed [IN_WIDTH:0] bias;
        ext  = {x[IN_WIDTH-1], x};
        bias = '0;
        if (s != '0) begin
            bias = (IN_WIDTH + 1)'(1) << (s - SHIFT_W'(1));
        end
        return (ext + bias) >>> s;
    endfunction

    // Symmetric clamp: the most negative LLR code is never produced.
    function automatic logic signed [LLR_WIDTH-1:0] sat_llr(
        input logic signed [IN_WIDTH:0] x
    );
        logic signed [IN_WIDTH:0] hi;
        logic signed [IN_WIDTH:0] lo;
        hi = (IN_WIDTH + 1)'(LMAX);
        lo = -hi;
        if (x > hi) begin
            return hi[LLR_WIDTH-1:0];
        end else if (x < lo) begin
            return lo[LLR_WIDTH-1:0];
        end
        return x[LLR_WIDTH-1:0];
    endfunction

    assign dout = sat_llr(round_shift(din, shift));

endmodule

// File: rtl/llr_phase_former.sv
// QPSK soft symbol -> signed LLR pair, with a trial phase rotation stepped by
// the sync system during lock search. Two-stage pipeline: rotate, quantize.
// Build option: define IQ_SWAP_EN to add four spectrally inverted phases (4..7).
module llr_phase_former
    import fano_pkg::*;
#(
    parameter int IN_WIDTH  = 8,
    parameter int LLR_WIDTH = 4,
    parameter int SHIFT_W   = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    llr_phase_former_if.slave    bus,
    input  logic [SHIFT_W-1:0]   i_shift,
    input  logic                 i_next_phase,
    input  logic                 i_llr_reset,
    output phase_t               o_phase,
    output logic                 o_last_phase_stb
);

`ifdef IQ_SWAP_EN
    localparam int NUM_PHASES = 2 * NUM_PHASES_BASE;
`else
    localparam int NUM_PHASES = NUM_PHASES_BASE;
`endif
    localparam phase_t LAST_PHASE = phase_t'(NUM_PHASES - 1);

    phase_t phase;
    logic   last_stb;

    logic en_p1;
    logic en_p2;
    logic vld_p1;
    logic vld_p2;

    logic signed [IN_WIDTH-1:0]  src_i_p0;
    logic signed [IN_WIDTH-1:0]  src_q_p0;
    logic signed [IN_WIDTH-1:0]  rot_i_p0;
    logic signed [IN_WIDTH-1:0]  rot_q_p0;
    logic signed [IN_WIDTH-1:0]  rot_i_p1;
    logic signed [IN_WIDTH-1:0]  rot_q_p1;
    logic signed [LLR_WIDTH-1:0] llr0_p1;
    logic signed [LLR_WIDTH-1:0] llr1_p1;
    logic signed [LLR_WIDTH-1:0] llr0_p2;
    logic signed [LLR_WIDTH-1:0] llr1_p2;

    function automatic logic signed [IN_WIDTH-1:0] neg_in(
        input logic signed [IN_WIDTH-1:0] x
    );
        return IN_WIDTH'(sat_neg(32'(x), IN_WIDTH));
    endfunction

    // Each stage advances when its output slot is empty or being drained.
    assign en_p2       = !vld_p2 || bus.m_ready;
    assign en_p1       = !vld_p1 || en_p2;
    assign bus.s_ready = en_p1;

    // Trial phase counter; reset wins over advance, strobe only on a real wrap.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            phase    <= '0;
            last_stb <= 1'b0;
        end else begin
            last_stb <= i_next_phase && !i_llr_reset && (phase == LAST_PHASE);
            if (i_llr_reset) begin
                phase <= '0;
            end else if (i_next_phase) begin
                phase <= (phase == LAST_PHASE) ? phase_t'(0) : phase + phase_t'(1);
            end
        end
    end

    // ---- stage 0 -> 1: optional I/Q swap, then quarter-turn rotation ----
    // Rotation uses the phase register as it stands at accept time.
    always_comb begin
        src_i_p0 = bus.s_i;
        src_q_p0 = bus.s_q;
`ifdef IQ_SWAP_EN
        if (phase[2]) begin
            src_i_p0 = bus.s_q;
            src_q_p0 = bus.s_i;
        end
`endif
        rot_i_p0 = src_i_p0;
        rot_q_p0 = src_q_p0;
        case (phase[1:0])
            2'd0: begin
                rot_i_p0 = src_i_p0;
                rot_q_p0 = src_q_p0;
            end
            2'd1: begin
                rot_i_p0 = neg_in(src_q_p0);
                rot_q_p0 = src_i_p0;
            end
            2'd2: begin
                rot_i_p0 = neg_in(src_i_p0);
                rot_q_p0 = neg_in(src_q_p0);
            end
            2'd3: begin
                rot_i_p0 = src_q_p0;
                rot_q_p0 = neg_in(src_i_p0);
            end
        endcase
    end

    // Stage 1 valid: loads on every enabled cycle, so an empty slot clears.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_p1 <= 1'b0;
        end else if (en_p1) begin
            vld_p1 <= bus.s_valid;
        end
    end

    // Stage 1 data: captured only for an accepted symbol.
    always_ff @(posedge clk) begin
        if (en_p1 && bus.s_valid) begin
            rot_i_p1 <= rot_i_p0;
            rot_q_p1 <= rot_q_p0;
        end
    end

    // ---- stage 1 -> 2: round, shift, saturate ----
    llr_quantizer #(
        .IN_WIDTH  (IN_WIDTH),
        .LLR_WIDTH (LLR_WIDTH),
        .SHIFT_W   (SHIFT_W)
    ) u_quant_i (
        .din   (rot_i_p1),
        .shift (i_shift),
        .dout  (llr0_p1)
    );

    llr_quantizer #(
        .IN_WIDTH  (IN_WIDTH),
        .LLR_WIDTH (LLR_WIDTH),
        .SHIFT_W   (SHIFT_W)
    ) u_quant_q (
        .din   (rot_q_p1),
        .shift (i_shift),
        .dout  (llr1_p1)
    );

    // Output register: holds valid and data while downstream stalls; cleared on reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_p2  <= 1'b0;
            llr0_p2 <= '0;
            llr1_p2 <= '0;
        end else if (en_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                llr0_p2 <= llr0_p1;
                llr1_p2 <= llr1_p1;
            end
        end
    end

    assign bus.m_valid      = vld_p2;
    assign bus.m_llr0       = llr0_p2;
    assign bus.m_llr1       = llr1_p2;
    assign o_phase          = phase;
    assign o_last_phase_stb = last_stb;

endmodule

// File: tb/tb_llr_phase_former.sv
// Directed bench for llr_phase_former: a 4-bit-LLR instance for the main checks
// and an 8-bit-LLR twin (same stimulus) where unsaturated values are needed.
module tb_llr_phase_former;

`ifdef IQ_SWAP_EN
    localparam int NPH = 8;
`else
    localparam int NPH = 4;
`endif

    logic              clk;
    logic              reset_n;
    logic              s_valid;
    logic              m_ready;
    logic signed [7:0] s_i;
    logic signed [7:0] s_q;
    logic [2:0]        shift;
    logic              next_phase;
    logic              llr_reset;
    logic [2:0]        phase4;
    logic [2:0]        phase8;
    logic              stb4;
    logic              stb8;

    int checks = 0;
    int errors = 0;

    llr_phase_former_if #(.IN_WIDTH(8), .LLR_WIDTH(4)) bus4 ();
    llr_phase_former_if #(.IN_WIDTH(8), .LLR_WIDTH(8)) bus8 ();

    assign bus4.s_valid = s_valid;
    assign bus4.s_i     = s_i;
    assign bus4.s_q     = s_q;
    assign bus4.m_ready = m_ready;
    assign bus8.s_valid = s_valid;
    assign bus8.s_i     = s_i;
    assign bus8.s_q     = s_q;
    assign bus8.m_ready = m_ready;

    llr_phase_former #(.IN_WIDTH(8), .LLR_WIDTH(4), .SHIFT_W(3)) u_dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .bus              (bus4),
        .i_shift          (shift),
        .i_next_phase     (next_phase),
        .i_llr_reset      (llr_reset),
        .o_phase          (phase4),
        .o_last_phase_stb (stb4)
    );

    llr_phase_former #(.IN_WIDTH(8), .LLR_WIDTH(8), .SHIFT_W(3)) u_dut8 (
        .clk              (clk),
        .reset_n          (reset_n),
        .bus              (bus8),
        .i_shift          (shift),
        .i_next_phase     (next_phase),
        .i_llr_reset      (llr_reset),
        .o_phase          (phase8),
        .o_last_phase_stb (stb8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_next();
        next_phase = 1'b1;
        step();
        next_phase = 1'b0;
    endtask

    task automatic pulse_reset_phase();
        llr_reset = 1'b1;
        step();
        llr_reset = 1'b0;
    endtask

    // Presents one symbol with the pipe empty and m_ready high; returns when
    // the result sits on the outputs (two edges after accept).
    task automatic send(input int i, input int q);
        s_i     = 8'(i);
        s_q     = 8'(q);
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        step();
        chk("send_m_valid", int'(bus4.m_valid), 1);
    endtask

    function automatic int m_neg(input int x);
        return (x == -128) ? 127 : -x;
    endfunction

    function automatic int m_quant(input int x, input int s, input int lim);
        int v;
        v = x;
        if (s > 0) v = (x + (1 << (s - 1))) >>> s;
        if (v > lim) v = lim;
        if (v < -lim) v = -lim;
        return v;
    endfunction

    function automatic void m_rot(input int i, input int q, input int p,
                                  output int ri, output int rq);
        case (p)
            1:       begin ri = m_neg(q); rq = i;        end
            2:       begin ri = m_neg(i); rq = m_neg(q); end
            3:       begin ri = q;        rq = m_neg(i); end
            default: begin ri = i;        rq = q;        end
        endcase
    endfunction

    initial begin
        int exp_i[4];
        int exp_q[4];
        int exp0_q[$];
        int exp1_q[$];
        int sent;
        int recv;
        int cyc;
        int mphase;
        int ri;
        int rq;
        int e0;
        int e1;

        reset_n    = 1'b0;
        s_valid    = 1'b0;
        m_ready    = 1'b1;
        s_i        = '0;
        s_q        = '0;
        shift      = 3'd0;
        next_phase = 1'b0;
        llr_reset  = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_m_valid", int'(bus4.m_valid), 0);
        chk("rst_llr0", int'(bus4.m_llr0), 0);
        chk("rst_llr1", int'(bus4.m_llr1), 0);
        chk("rst_phase", int'(phase4), 0);
        chk("rst_stb", int'(stb4), 0);
        chk("rst_s_ready", int'(bus4.s_ready), 1);
        reset_n = 1'b1;
        step();

        // Rotation through phases 0..3, 8-bit LLRs so nothing saturates
        exp_i = '{20, 7, -20, -7};
        exp_q = '{-7, 20, 7, -20};
        for (int p = 0; p < 4; p++) begin
            send(20, -7);
            chk($sformatf("rot_p%0d_llr0", p), int'(bus8.m_llr0), exp_i[p]);
            chk($sformatf("rot_p%0d_llr1", p), int'(bus8.m_llr1), exp_q[p]);
            chk($sformatf("rot_p%0d_phase", p), int'(phase8), p);
            step();
            chk("rot_drained", int'(bus4.m_valid), 0);
            if (p < 3) begin
                pulse_next();
                chk("rot_no_stb", int'(stb4), 0);
            end
        end
        send(20, -7);
        chk("rot_p3_llr0_sat4", int'(bus4.m_llr0), -7);
        chk("rot_p3_llr1_sat4", int'(bus4.m_llr1), -7);
        step();

        // Wrap: strobe once, the cycle after the final pulse
        pulse_reset_phase();
        chk("wrap_start_phase", int'(phase4), 0);
        chk("wrap_start_stb", int'(stb4), 0);
        for (int k = 1; k <= NPH; k++) begin
            pulse_next();
            chk($sformatf("wrap_phase_%0d", k), int'(phase4), k % NPH);
            chk($sformatf("wrap_stb_%0d", k), int'(stb4), (k == NPH) ? 1 : 0);
        end
        step();
        chk("wrap_stb_single", int'(stb4), 0);

        // Saturation: phase 2 on (-128,127)
        pulse_next();
        pulse_next();
        chk("sat_phase2", int'(phase4), 2);
        send(-128, 127);
        chk("sat_neg_llr0", int'(bus4.m_llr0), 7);
        chk("sat_neg_llr1", int'(bus4.m_llr1), -7);
        chk("sat_neg_llr0_8b", int'(bus8.m_llr0), 127);
        chk("sat_neg_llr1_8b", int'(bus8.m_llr1), -127);
        step();
        pulse_reset_phase();
        chk("llr_reset_phase", int'(phase4), 0);
        chk("llr_reset_no_stb", int'(stb4), 0);
        shift = 3'd3;
        send(100, -100);
        chk("sat_shift3_llr0", int'(bus4.m_llr0), 7);
        chk("sat_shift3_llr1", int'(bus4.m_llr1), -7);
        chk("shift3_llr0_8b", int'(bus8.m_llr0), 13);
        chk("shift3_llr1_8b", int'(bus8.m_llr1), -12);
        step();

        // Rounding half up
        shift = 3'd1;
        send(5, -5);
        chk("round_5_s1", int'(bus4.m_llr0), 3);
        chk("round_m5_s1", int'(bus4.m_llr1), -2);
        step();
        shift = 3'd2;
        send(1, -6);
        chk("round_1_s2", int'(bus4.m_llr0), 0);
        chk("round_m6_s2", int'(bus4.m_llr1), -1);
        step();
        shift = 3'd0;

        // Simultaneous advance and reset at phase 3
        pulse_next();
        pulse_next();
        pulse_next();
        chk("simul_pre_phase", int'(phase4), 3);
        next_phase = 1'b1;
        llr_reset  = 1'b1;
        step();
        next_phase = 1'b0;
        llr_reset  = 1'b0;
        chk("simul_phase", int'(phase4), 0);
        chk("simul_no_stb", int'(stb4), 0);
        step();
        chk("simul_no_stb_late", int'(stb4), 0);

        // Phase pulse coinciding with an accept: that symbol keeps the old phase
        s_i        = 8'sd3;
        s_q        = 8'sd4;
        s_valid    = 1'b1;
        next_phase = 1'b1;
        step();
        next_phase = 1'b0;
        s_i        = 8'sd5;
        s_q        = 8'sd6;
        step();
        s_valid = 1'b0;
        chk("mid_first_valid", int'(bus4.m_valid), 1);
        chk("mid_first_llr0", int'(bus4.m_llr0), 3);
        chk("mid_first_llr1", int'(bus4.m_llr1), 4);
        step();
        chk("mid_second_valid", int'(bus4.m_valid), 1);
        chk("mid_second_llr0", int'(bus4.m_llr0), -6);
        chk("mid_second_llr1", int'(bus4.m_llr1), 5);
        chk("mid_phase", int'(phase4), 1);
        step();

        // Backpressure burst with a one-cycle reset in the middle
        pulse_reset_phase();
        pulse_next();
        pulse_next();
        pulse_next();
        shift  = 3'd2;
        mphase = 3;
        sent   = 0;
        recv   = 0;
        cyc    = 0;
        while ((sent < 1000 || exp0_q.size() != 0) && cyc < 20000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 400) begin
                reset_n = 1'b0;
                s_valid = 1'b0;
                m_ready = 1'b1;
                step();
                reset_n = 1'b1;
                chk("mid_rst_m_valid", int'(bus4.m_valid), 0);
                chk("mid_rst_phase", int'(phase4), 0);
                chk("mid_rst_s_ready", int'(bus4.s_ready), 1);
                exp0_q.delete();
                exp1_q.delete();
                mphase = 0;
                continue;
            end
            m_ready = ($urandom_range(0, 99) < 30);
            if (sent < 1000) begin
                s_valid = 1'b1;
                s_i     = 8'($urandom_range(0, 255));
                s_q     = 8'($urandom_range(0, 255));
            end else begin
                s_valid = 1'b0;
            end
            #2;
            if (bus4.m_valid && m_ready) begin
                if (exp0_q.size() == 0) begin
                    chk("burst_unexpected", exp0_q.size(), 1);
                end else begin
                    e0 = exp0_q.pop_front();
                    e1 = exp1_q.pop_front();
                    chk("burst_llr0", int'(bus4.m_llr0), e0);
                    chk("burst_llr1", int'(bus4.m_llr1), e1);
                    recv++;
                end
            end
            if (s_valid && bus4.s_ready) begin
                m_rot(int'(s_i), int'(s_q), mphase, ri, rq);
                exp0_q.push_back(m_quant(ri, 2, 7));
                exp1_q.push_back(m_quant(rq, 2, 7));
                sent++;
            end
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        chk("burst_sent", sent, 1000);
        chk("burst_drained", exp0_q.size(), 0);
        step();
        step();
        chk("burst_idle", int'(bus4.m_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
